// File: rtl/axi_mem_slave.sv
// AXI4 slave memory model: independent write and read burst engines (INCR only)
// over a word array with a per-word user shadow.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting awlen+1 write beats
// W_RESP | bvalid high, holding the write response until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, streaming arlen+1 read beats
module axi_mem_slave #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 1,
  parameter int SLVERR_ON_LAST = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic [USER_WIDTH-1:0]   wuser,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic [USER_WIDTH-1:0]   buser,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast,
  output logic [USER_WIDTH-1:0]   ruser,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - BSH;
  localparam int DEPTH = 2 ** IW;
  localparam logic [IW-1:0] IDX_ONE = 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem  [DEPTH];
  logic [USER_WIDTH-1:0] umem [DEPTH];

  logic [1:0]    w_state;
  logic [IW-1:0] widx;
  logic [7:0]    wcnt;
  logic          werr;
  logic          wr_fire;
  logic          beat_err;

  logic          r_state;
  logic [IW-1:0] ridx;
  logic [7:0]    rcnt;

  // Byte offset bits never select anything; words are always full-width.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[BSH-1:0], araddr[BSH-1:0]};

  assign rresp    = 2'b00;
  assign wr_fire  = (w_state == W_DATA) && wvalid && wready;
  assign beat_err = (wcnt == 8'd0) ? !wlast : wlast;

  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
      umem[widx] <= wuser;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      widx    <= '0;
      wcnt    <= '0;
      werr    <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      buser   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            widx    <= awaddr[ADDR_WIDTH-1:BSH];
            wcnt    <= awlen;
            werr    <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            widx <= widx + IDX_ONE;
            if (wcnt == 8'd0) begin
              // Burst length comes from awlen; wlast only feeds the error flag.
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= ((SLVERR_ON_LAST != 0) && (werr || beat_err)) ? 2'b10 : 2'b00;
              buser   <= wuser;
              w_state <= W_RESP;
            end else begin
              werr <= werr | beat_err;
              wcnt <= wcnt - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            buser   <= '0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Beat loads read mem with the pre-edge value, so a same-edge write is seen
  // only by later loads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      ridx    <= '0;
      rcnt    <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      ruser   <= '0;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= mem[araddr[ADDR_WIDTH-1:BSH]];
            ruser   <= umem[araddr[ADDR_WIDTH-1:BSH]];
            rlast   <= (arlen == 8'd0);
            ridx    <= araddr[ADDR_WIDTH-1:BSH] + IDX_ONE;
            rcnt    <= arlen;
            r_state <= R_DATA;
          end
        end
        default: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata <= mem[ridx];
              ruser <= umem[ridx];
              rlast <= (rcnt == 8'd1);
              ridx  <= ridx + IDX_ONE;
              rcnt  <= rcnt - 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, wrap, wlast errors,
// backpressure, concurrency and mid-burst reset.
module tb_axi_mem_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [9:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [0:0]  wuser;

  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [0:0]  buser, ruser;
  logic [31:0] rdata;

  logic        x_awready, x_wready, x_bvalid, x_arready, x_rvalid, x_rlast;
  logic [1:0]  x_bresp, x_rresp;
  logic [0:0]  x_buser, x_ruser;
  logic [31:0] x_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic        wu [16];
  logic [31:0] rexp [16];
  logic        ruexp [16];

  always #5 aclk = ~aclk;

  axi_mem_slave #(.SLVERR_ON_LAST(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .ruser(ruser), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi_mem_slave #(.SLVERR_ON_LAST(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(x_awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(x_wready),
    .bresp(x_bresp), .buser(x_buser), .bvalid(x_bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(x_arready),
    .rdata(x_rdata), .rlast(x_rlast), .ruser(x_ruser), .rresp(x_rresp), .rvalid(x_rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [7:0] len, input int bhold,
                          input logic [1:0] exp_resp, input logic [1:0] exp_resp0,
                          input logic exp_buser);
    int n;
    awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
    chk("aw_wait", 32'(n < 100), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    chk("wready_after_aw", 32'(wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wuser = wu[i]; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge aclk); #1; n++; end
      chk("w_wait", 32'(n < 100), 32'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wready_drop", 32'(wready), 32'd0);
    chk("bvalid_lat", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("bresp_noerr_cfg", 32'(x_bresp), 32'(exp_resp0));
    chk("buser", 32'(buser), 32'(exp_buser));
    for (int h = 0; h < bhold; h++) begin
      @(posedge aclk); #1;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(exp_resp));
      chk("buser_hold", 32'(buser), 32'(exp_buser));
      chk("awready_hold", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input int stall_beat);
    int n;
    araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
    chk("ar_wait", 32'(n < 100), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, rexp[i]);
      chk("rlast", 32'(rlast), 32'(i == int'(len)));
      chk("ruser", 32'(ruser), 32'(ruexp[i]));
      if (i == stall_beat) begin
        rready = 1'b0;
        repeat (2) begin
          @(posedge aclk); #1;
          chk("rvalid_stall", 32'(rvalid), 32'd1);
          chk("rdata_stall", rdata, rexp[i]);
          chk("rlast_stall", 32'(rlast), 32'(i == int'(len)));
        end
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
    end
    chk("rvalid_end", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd[i] = '0; ws[i] = 4'hF; wl[i] = 1'b0; wu[i] = 1'b0; rexp[i] = '0; ruexp[i] = 1'b0;
    end

    // reset values
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #11 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_arready", 32'(arready), 32'd1);
    chk("post_rst_wready", 32'(wready), 32'd0);

    // basic 4-beat burst
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 3); wu[i] = 1'b0;
      rexp[i] = 32'hA0 + 32'(i); ruexp[i] = 1'b0;
    end
    do_write(10'h010, 8'd3, 0, 2'b00, 2'b00, 1'b0);
    do_read(10'h010, 8'd3, -1);

    // byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1; wu[0] = 1'b0;
    do_write(10'h000, 8'd0, 0, 2'b00, 2'b00, 1'b0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h5;
    do_write(10'h000, 8'd0, 0, 2'b00, 2'b00, 1'b0);
    rexp[0] = 32'h11FF33FF; ruexp[0] = 1'b0;
    do_read(10'h000, 8'd0, -1);

    // wrap past the top of memory
    wd[0] = 32'hB0; wd[1] = 32'hB1; ws[0] = 4'hF; ws[1] = 4'hF;
    wl[0] = 1'b0; wl[1] = 1'b1; wu[0] = 1'b0; wu[1] = 1'b0;
    do_write(10'h3FC, 8'd1, 0, 2'b00, 2'b00, 1'b0);
    rexp[0] = 32'hB0; ruexp[0] = 1'b0;
    do_read(10'h3FC, 8'd0, -1);
    rexp[0] = 32'hB1;
    do_read(10'h000, 8'd0, -1);
    rexp[0] = 32'hB0; rexp[1] = 32'hB1; ruexp[1] = 1'b0;
    do_read(10'h3FC, 8'd1, -1);

    // early wlast on beat 2 of 4: all beats land, SLVERR only when enabled
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 1); wu[i] = (i == 3);
      rexp[i] = 32'hC0 + 32'(i); ruexp[i] = (i == 3);
    end
    do_write(10'h020, 8'd3, 0, 2'b10, 2'b00, 1'b1);
    do_read(10'h020, 8'd3, 1);

    // missing wlast on final beat
    wd[0] = 32'hD0; wd[1] = 32'hD1; wl[0] = 1'b0; wl[1] = 1'b0; wu[0] = 1'b0; wu[1] = 1'b0;
    do_write(10'h040, 8'd1, 0, 2'b10, 2'b00, 1'b0);

    // B backpressure for 5 cycles
    wd[0] = 32'hD2; wd[1] = 32'hD3; wl[0] = 1'b0; wl[1] = 1'b1; wu[0] = 1'b0; wu[1] = 1'b1;
    do_write(10'h050, 8'd1, 5, 2'b00, 2'b00, 1'b1);

    // overlapping write and read on disjoint words
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hE0 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 3); wu[i] = (i == 1);
      rexp[i] = 32'hA0 + 32'(i); ruexp[i] = 1'b0;
    end
    fork
      do_write(10'h080, 8'd3, 0, 2'b00, 2'b00, 1'b0);
      do_read(10'h010, 8'd3, -1);
    join
    for (int i = 0; i < 4; i++) begin
      rexp[i] = 32'hE0 + 32'(i); ruexp[i] = (i == 1);
    end
    do_read(10'h080, 8'd3, -1);

    // reset in the middle of both bursts
    araddr = 10'h010; arlen = 8'd3; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    awaddr = 10'h100; awlen = 8'd3; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    chk("pre_rst_wready", 32'(wready), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_bresp", 32'(bresp), 32'd0);
    chk("mid_rst_buser", 32'(buser), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_rlast", 32'(rlast), 32'd0);
    chk("mid_rst_ruser", 32'(ruser), 32'd0);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);
    chk("rel_wready", 32'(wready), 32'd0);
    chk("rel_rvalid", 32'(rvalid), 32'd0);
    chk("rresp_zero", 32'(rresp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave memory model: the real DUT between the master-side and slave-side `axi_if` in the AXI bench.
- Replaces the pass-through wiring there.
- Consumes master AW/W/AR traffic; produces B/R responses from an internal word array.
- Independent write and read engines; INCR bursts only, since the interface carries no burst-type field.

Parameters:
- ADDR_WIDTH, 10, byte address width of awaddr/araddr.
- DATA_WIDTH, 32, data bus width; multiple of 8, power of two.
- USER_WIDTH, 1, width of wuser/buser/ruser.
- SLVERR_ON_LAST, 1, 1 = report SLVERR on wlast/beat-count mismatch; 0 = always OKAY.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- awaddr  in  ADDR_WIDTH  write burst start byte address
- awlen  in  8  write beats minus 1
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wlast  in  1  last write beat
- wuser  in  USER_WIDTH  per-beat user
- wvalid  in  1  W valid
- wready  out  1  W ready
- bresp  out  2  write response
- buser  out  USER_WIDTH  write response user
- bvalid  out  1  B valid
- bready  in  1  B ready
- araddr  in  ADDR_WIDTH  read burst start byte address
- arlen  in  8  read beats minus 1
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rdata  out  DATA_WIDTH  read data
- rlast  out  1  last read beat
- ruser  out  USER_WIDTH  read user
- rresp  out  2  read response (always OKAY)
- rvalid  out  1  R valid
- rready  in  1  R ready

Behaviour:
- Clock and reset: one clock, `aclk`. Reset is `aresetn`, asynchronous and active-low.
- Reset values: all outputs 0; both FSMs go to IDLE; counters cleared. Memory and user arrays are not reset.
- Mid-burst reset aborts the burst. No response is issued for it.
- Storage:
  - DEPTH = 2**ADDR_WIDTH/(DATA_WIDTH/8) words, plus a USER_WIDTH-wide shadow word per data word.
  - Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored.
  - Beat n of a burst uses index (start+n) mod DEPTH, so bursts wrap past the top of memory.
- Handshake rules: a transfer occurs on a rising edge with valid && ready. Ready and valid outputs are registered. No combinational path from inputs to outputs.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch index and awlen into wcnt, clear the error flag, then go to W_DATA with awready=0 and wready=1 on the next cycle.
  - W_DATA: on each W handshake, write the bytes whose wstrb bit is 1 and store wuser in the shadow word. The shadow word is written even when wstrb=0.
    - Error flag sets if wlast=1 while wcnt!=0.
    - Error flag sets if wlast=0 on the awlen+1-th beat.
    - The burst ends after beat awlen+1 regardless of wlast.
    - wready drops the cycle after the final beat.
  - W_RESP: bvalid=1. bresp = 2'b10 if (error flag && SLVERR_ON_LAST), else 2'b00. buser = wuser of the final beat.
    - bvalid, bresp and buser stay stable until bready.
    - After the B handshake, go to W_IDLE with awready=1 on the next cycle.
  - W beats arriving before the AW handshake are not accepted (wready=0).
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch index and arlen, go to R_DATA, and load beat 0 into the output registers. rvalid=1 on the cycle after the AR handshake (latency 1).
  - R_DATA: rdata, ruser and rlast are stable while rvalid && !rready.
    - On an R handshake of a non-last beat, load the next beat, so back-to-back beats stream at 1 per cycle.
    - rlast=1 only on beat arlen+1.
    - After the last handshake, rvalid drops and the FSM returns to R_IDLE with arready=1 on the next cycle.
  - rresp is always 2'b00.
- Simultaneous write and read of the same word on one edge: the read captures the old data and user value. The write is visible to any later beat load.
- The write and read engines run fully concurrently. One outstanding burst per direction; no IDs, no reordering.

Test Plan:
- Write awaddr=0x010, awlen=3, wdata=0xA0..0xA3, wstrb=0xF, wlast on beat 4, bready=1 -> bvalid with bresp=00 one cycle after the last beat. Then read araddr=0x010, arlen=3, rready=1 -> rvalid 1 cycle after AR, beats 0xA0..0xA3 on consecutive cycles, rlast only on the 4th.
- Byte strobes: write 0x11223344 to 0x000, then write 0xFFFFFFFF with wstrb=0x5 -> readback 0x11FF33FF.
- Wrap: awaddr=0x3FC, awlen=1, data 0xB0,0xB1 -> read of 0x3FC returns 0xB0 and read of 0x000 returns 0xB1.
- wlast early on beat 2 of awlen=3 -> all 4 beats accepted, bresp=2'b10. Rerun with SLVERR_ON_LAST=0 -> bresp=2'b00.
- Backpressure:
  - rready toggled 1,0,0,1 -> rdata and rlast hold during the stall and no beat is skipped.
  - bready held 0 for 5 cycles -> bvalid, bresp and buser stable, and awready stays 0.
- Concurrency and reset:
  - A write burst and a read burst to disjoint words overlap and both complete correctly; wuser=1 on a beat -> that word reads back with ruser=1.
  - aresetn pulsed low mid-burst -> all outputs go to 0 immediately, and awready and arready return to 1 on the first aclk edge after release.
